// File: rtl/dht11_reader.sv
// DHT11 single-wire master: start pulse, response timing, 40-bit capture,
// checksum check. Line is only ever pulled low (open-drain via dht_oe).
module dht11_reader #(
  parameter int US_DIV        = 50,
  parameter int START_LOW_US  = 18000,
  parameter int BIT_THRESH_US = 40,
  parameter int TIMEOUT_US    = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dht_in,
  output logic       dht_oe,
  output logic       busy,
  output logic       valid,
  output logic       error,
  output logic [1:0] err_code,
  output logic [7:0] hum_int,
  output logic [7:0] hum_dec,
  output logic [7:0] temp_int,
  output logic [7:0] temp_dec
);

  localparam int PW = (US_DIV > 1) ? $clog2(US_DIV) : 1;

  typedef enum logic [3:0] {
    IDLE, START_LOW, RELEASE, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK, ERR
  } state_t;

  state_t        state, state_nx;
  logic [1:0]    err_nx;
  logic [PW-1:0] pre_cnt;
  logic          us_tick;
  logic [15:0]   us_cnt;
  logic          s1, s2, s3;
  logic          rise, fall;
  logic [5:0]    bit_idx;
  logic [39:0]   sh;
  logic [7:0]    sum;
  logic          sum_ok;
  logic          timeout;
  logic          bit_val;

  // Edges come from the synchronized copy and its one-clk delayed version.
  assign rise    = s2 & ~s3;
  assign fall    = ~s2 & s3;
  assign us_tick = (pre_cnt == PW'(US_DIV - 1));
  assign timeout = (us_cnt > 16'(TIMEOUT_US));
  assign bit_val = (us_cnt > 16'(BIT_THRESH_US));
  assign sum     = sh[39:32] + sh[31:24] + sh[23:16] + sh[15:8];
  assign sum_ok  = (sum == sh[7:0]);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; err_nx carries the code for a transition into ERR.
  // A start that lands on the done pulse (busy just fell) is dropped.
  always_comb begin
    state_nx = state;
    err_nx   = 2'b00;
    case (state)
      IDLE:      if (start && !valid && !error) state_nx = START_LOW;
      START_LOW: if (us_cnt == 16'(START_LOW_US)) state_nx = RELEASE;
      RELEASE: begin
        if (fall)         state_nx = RESP_LOW;
        else if (timeout) begin state_nx = ERR; err_nx = 2'b01; end
      end
      RESP_LOW: begin
        if (rise)         state_nx = RESP_HIGH;
        else if (timeout) begin state_nx = ERR; err_nx = 2'b01; end
      end
      RESP_HIGH: begin
        if (fall)         state_nx = BIT_LOW;
        else if (timeout) begin state_nx = ERR; err_nx = 2'b01; end
      end
      BIT_LOW: begin
        if (rise)         state_nx = BIT_HIGH;
        else if (timeout) begin state_nx = ERR; err_nx = 2'b10; end
      end
      BIT_HIGH: begin
        if (fall)         state_nx = (bit_idx == 6'd39) ? CHECK : BIT_LOW;
        else if (timeout) begin state_nx = ERR; err_nx = 2'b10; end
      end
      CHECK:   state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Decoded outputs straight from state so reset releases the line at once
  always_comb begin
    dht_oe = (state == START_LOW);
    busy   = (state != IDLE);
  end

  // Synchronizer, microsecond timebase, bit capture and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= 1'b1;
      s2       <= 1'b1;
      s3       <= 1'b1;
      pre_cnt  <= '0;
      us_cnt   <= '0;
      bit_idx  <= '0;
      sh       <= '0;
      valid    <= 1'b0;
      error    <= 1'b0;
      err_code <= 2'b00;
      hum_int  <= '0;
      hum_dec  <= '0;
      temp_int <= '0;
      temp_dec <= '0;
    end else begin
      s1 <= dht_in;
      s2 <= s1;
      s3 <= s2;

      if (state_nx != state) begin
        pre_cnt <= '0;
        us_cnt  <= '0;
      end else if (us_tick) begin
        pre_cnt <= '0;
        if (us_cnt != 16'hFFFF) us_cnt <= us_cnt + 16'd1;
      end else begin
        pre_cnt <= pre_cnt + PW'(1);
      end

      if (state == RESP_HIGH && fall) bit_idx <= '0;
      if (state == BIT_HIGH && fall) begin
        sh      <= {sh[38:0], bit_val};
        bit_idx <= bit_idx + 6'd1;
      end

      valid <= (state == CHECK) && sum_ok;
      error <= (state == ERR) || ((state == CHECK) && !sum_ok);

      if (state == IDLE && state_nx == START_LOW) err_code <= 2'b00;
      else if (state_nx == ERR)                   err_code <= err_nx;
      else if (state == CHECK && !sum_ok)         err_code <= 2'b11;

      if (state == CHECK && sum_ok) begin
        hum_int  <= sh[39:32];
        hum_dec  <= sh[31:24];
        temp_int <= sh[23:16];
        temp_dec <= sh[15:8];
      end
    end
  end

endmodule

// File: tb/tb_dht11_reader.sv
// Bench for dht11_reader: behavioural sensor drives the line, expected
// results are queued per request and a monitor checks every valid/error pulse.
module tb_dht11_reader;
  localparam int START_LOW_US = 20;
  localparam int TIMEOUT_US   = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       sens = 1'b1;
  logic       dht_oe, busy, valid, error;
  logic [1:0] err_code;
  logic [7:0] hum_int, hum_dec, temp_int, temp_dec;
  wire        dht_in = dht_oe ? 1'b0 : sens;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        ok;
    logic [1:0]  code;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  dht11_reader #(
    .US_DIV(1), .START_LOW_US(START_LOW_US), .BIT_THRESH_US(40), .TIMEOUT_US(TIMEOUT_US)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dht_in(dht_in), .dht_oe(dht_oe),
    .busy(busy), .valid(valid), .error(error), .err_code(err_code),
    .hum_int(hum_int), .hum_dec(hum_dec), .temp_int(temp_int), .temp_dec(temp_dec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic push(input logic ok, input logic [1:0] code, input logic [31:0] data);
    exp_t e;
    e.ok = ok; e.code = code; e.data = data;
    sb.push_back(e);
  endtask

  // Monitor: every result pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n && (valid || error)) begin
      exp_t e;
      chk("pulse_exclusive", 32'(valid & error), 32'd0);
      chk("busy_at_pulse", 32'(busy), 32'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got valid=%0b error=%0b, required no pulse", valid, error);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind_valid", 32'(valid), 32'(e.ok));
        chk("err_code", 32'(err_code), 32'(e.code));
        chk("data_bytes", {hum_int, hum_dec, temp_int, temp_dec}, e.data);
      end
    end
  end

  // Issue a read and play the sensor side of the exchange.
  task automatic read_frame(input logic [39:0] fr, input int h0, input int h1,
                            input int poke_bit, input int abort_bit, input bit silent);
    int n;
    bit oe_bad;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0;
    while (!dht_oe && n < 20) begin @(negedge clk); n++; end
    chk("start_low_seen", 32'(dht_oe), 32'd1);
    chk("busy_in_frame", 32'(busy), 32'd1);
    chk("err_code_cleared", 32'(err_code), 32'd0);
    n = 0;
    while (dht_oe && n < 1000) begin @(negedge clk); n++; end
    chk_rng("start_low_len", n, START_LOW_US, START_LOW_US + 1);
    oe_bad = 1'b0;
    if (!silent) begin
      repeat (20) @(negedge clk);
      sens = 1'b0; repeat (80) @(negedge clk);
      sens = 1'b1; repeat (80) @(negedge clk);
      for (int i = 0; i < 40; i++) begin
        if (i == abort_bit) begin
          rst_n = 1'b0;
          #1;
          chk("abort_oe", 32'(dht_oe), 32'd0);
          chk("abort_busy", 32'(busy), 32'd0);
          repeat (3) @(negedge clk);
          rst_n = 1'b1;
          sens = 1'b1;
          chk("abort_data_cleared", {hum_int, hum_dec, temp_int, temp_dec}, 32'd0);
          repeat (10) @(negedge clk);
          return;
        end
        sens = 1'b0;
        if (i == poke_bit) begin
          start = 1'b1;
          @(negedge clk) start = 1'b0;
          repeat (49) @(negedge clk);
        end else begin
          repeat (50) @(negedge clk);
        end
        sens = 1'b1;
        repeat (fr[39-i] ? h1 : h0) @(negedge clk);
      end
      sens = 1'b0;
    end
    n = 0;
    while (!(valid || error) && n < 600) begin
      @(negedge clk);
      n++;
      if (dht_oe) oe_bad = 1'b1;
    end
    if (n >= 600) begin
      checks++;
      errors++;
      $display("FAIL pulse_timeout: got no pulse in %0d clks, required one", n);
    end
    if (silent) begin
      chk("oe_during_wait", 32'(oe_bad), 32'd0);
      chk_rng("no_response_wait", n, TIMEOUT_US, TIMEOUT_US + 10);
    end
    if (poke_bit >= 0) begin
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int k = 0; k < 4; k++) begin
        chk("start_on_done_ignored", 32'(busy), 32'd0);
        @(negedge clk);
      end
    end else begin
      @(negedge clk);
    end
    chk("busy_idle_after", 32'(busy), 32'd0);
    repeat (45) @(negedge clk);
    sens = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish before 2 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_oe", 32'(dht_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    chk("rst_data", {hum_int, hum_dec, temp_int, temp_dec}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // good frame: 53 %RH, 24 C
    push(1'b1, 2'b00, 32'h35001800);
    read_frame(40'h350018004D, 26, 70, -1, -1, 1'b0);
    // bad checksum keeps previous data
    push(1'b0, 2'b11, 32'h35001800);
    read_frame(40'h350018004E, 26, 70, -1, -1, 1'b0);
    // silent sensor
    push(1'b0, 2'b01, 32'h35001800);
    read_frame(40'h0, 26, 70, -1, -1, 1'b1);
    // 30 us high -> 0, 60 us high -> 1
    push(1'b1, 2'b00, 32'hAA550FF0);
    read_frame(40'hAA550FF0FE, 30, 60, -1, -1, 1'b0);
    // start pulses mid-frame and on the done cycle are ignored
    push(1'b1, 2'b00, 32'h35001800);
    read_frame(40'h350018004D, 26, 70, 10, -1, 1'b0);
    // reset at bit 17, then a clean frame
    read_frame(40'h350018004D, 26, 70, -1, 17, 1'b0);
    chk("post_abort_err_code", 32'(err_code), 32'd0);
    push(1'b1, 2'b00, 32'h12013405);
    read_frame(40'h120134054C, 26, 70, -1, -1, 1'b0);

    repeat (20) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
